// File: rtl/axis_status_sink.sv
// AXI-stream status sink: rate-limited acceptance of a status word, with a
// saturating beat counter and a change-detect pulse.
module axis_status_sink #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = 32
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        cfg_hold,
  input  logic [CNTR_WIDTH-1:0]       cfg_rate,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] sts_data,
  output logic [CNTR_WIDTH-1:0]       sts_count,
  output logic                        sts_changed
);

  // state | meaning
  // WAIT  | idle gap after a beat (or after reset/hold), counting up to cfg_rate
  // READY | tready high, waiting for a beat
  // HOLD  | frozen by cfg_hold, nothing accepted
  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    READY = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CNTR_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [CNTR_WIDTH-1:0] CNT_ONE  = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};

  state_t                state;
  state_t                next_state;
  logic [CNTR_WIDTH-1:0] cntr;
  logic [CNTR_WIDTH-1:0] next_cntr;
  logic                  accept;

  assign s_axis_tready = (state == READY);
  assign accept        = s_axis_tvalid & s_axis_tready;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= WAIT;
      cntr  <= CNT_ZERO;
    end else begin
      state <= next_state;
      cntr  <= next_cntr;
    end
  end

  always_comb begin
    next_state = state;
    next_cntr  = cntr;
    case (state)
      WAIT: begin
        // >= rather than == so a lowered cfg_rate releases the gap at once
        if (cfg_hold) begin
          next_state = HOLD;
        end else if (cntr >= cfg_rate) begin
          next_state = READY;
        end else begin
          next_cntr = cntr + CNT_ONE;
        end
      end
      READY: begin
        if (cfg_hold) begin
          next_state = HOLD;
        end else if (accept && (cfg_rate != CNT_ZERO)) begin
          next_state = WAIT;
          next_cntr  = CNT_ONE;
        end
      end
      HOLD: begin
        if (!cfg_hold) begin
          next_state = WAIT;
          next_cntr  = CNT_ZERO;
        end
      end
      default: begin
        next_state = WAIT;
        next_cntr  = CNT_ZERO;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      sts_data    <= '0;
      sts_count   <= '0;
      sts_changed <= 1'b0;
    end else if (accept) begin
      sts_data    <= s_axis_tdata;
      sts_changed <= (s_axis_tdata != sts_data);
      if (sts_count != {CNTR_WIDTH{1'b1}}) begin
        sts_count <= sts_count + CNT_ONE;
      end
    end else begin
      sts_changed <= 1'b0;
    end
  end

endmodule

// File: doc/axis_status_sink.md
AXIS_STATUS_SINK -- requirements
Module: axis_status_sink

Interface
REQ-001 Parameter AXIS_TDATA_WIDTH, default 32, width of the stream data and the status value.
REQ-002 Parameter CNTR_WIDTH, default 32, width of the rate counter, cfg_rate and sts_count.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 aclk  input  1  system clock; all state updates on its rising edge.
REQ-005 areset  input  1  synchronous active-high reset.
REQ-006 cfg_hold  input  1  freeze request; while high, no beats are accepted.
REQ-007 cfg_rate  input  CNTR_WIDTH  number of idle (tready low) cycles inserted after each accepted beat.
REQ-008 s_axis_tdata  input  AXIS_TDATA_WIDTH  slave stream data.
REQ-009 s_axis_tvalid  input  1  slave stream valid.
REQ-010 s_axis_tready  output  1  slave stream ready.
REQ-011 sts_data  output  AXIS_TDATA_WIDTH  last accepted data value.
REQ-012 sts_count  output  CNTR_WIDTH  number of accepted beats, saturating.
REQ-013 sts_changed  output  1  one-cycle pulse when an accepted beat differs from the previous sts_data.

Function
REQ-014 A beat SHALL be accepted in a cycle iff s_axis_tvalid and s_axis_tready are both high.
REQ-015 FSM states SHALL be WAIT, READY and HOLD; s_axis_tready SHALL be high only in READY and decoded from the registered state.
REQ-016 WAIT: if cfg_hold is high, go to HOLD; else if counter >= cfg_rate, go to READY; else increment counter.
REQ-017 READY, no accept: if cfg_hold is high, go to HOLD; else stay in READY.
REQ-018 READY, accept: if cfg_hold is high, go to HOLD (the beat is still accepted); else if cfg_rate == 0, stay in READY; else go to WAIT with counter = 1.
REQ-019 With cfg_rate = N > 0, s_axis_tready SHALL be low for exactly N cycles after each accept (one beat per N+1 cycles); with N = 0, acceptance SHALL be full rate.
REQ-020 HOLD: when cfg_hold is low, go to WAIT with counter = 0; otherwise remain in HOLD.
REQ-021 cfg_rate SHALL be sampled every cycle; if it is lowered below the counter during WAIT, the FSM goes to READY at the next edge.
REQ-022 On accept, sts_data SHALL load s_axis_tdata at that edge (1-cycle latency).
REQ-023 On accept, sts_count SHALL increment by 1 and hold at all-ones, with no wrap.
REQ-024 On accept, sts_changed SHALL be 1 for the following cycle iff s_axis_tdata != the pre-edge sts_data; otherwise it is 0.
REQ-025 s_axis_tdata SHALL be ignored when no beat is accepted; s_axis_tvalid may toggle freely, and a dropped tvalid simply defers acceptance.

Reset
REQ-026 While areset is high, the block SHALL set state = WAIT, counter = 0, sts_data = 0, sts_count = 0, sts_changed = 0, so s_axis_tready = 0.
REQ-027 Reset SHALL take priority over every other event, including an accept in the same cycle, which is discarded.
REQ-028 After reset release, the first READY SHALL occur after cfg_rate+1 WAIT cycles if cfg_hold is low.
REQ-029 The first accepted beat after reset SHALL be compared against sts_data = 0 for sts_changed.

Verification
REQ-030 cfg_rate=0, tvalid held high, data 1,2,3 after reset -> tready high from the 2nd cycle after release; three consecutive accepts; sts_count=3; sts_data=3; sts_changed high for 3 cycles.
REQ-031 cfg_rate=3, tvalid held high -> tready pattern 1,0,0,0,1,0,0,0; sts_count advances once per 4 cycles.
REQ-032 Repeated data 0x5 twice, then 0x5 again -> sts_changed pulses on the first beat only; sts_count increments on all three.
REQ-033 cfg_hold raised during the accept cycle of data 0xA -> 0xA is captured, tready stays low while held; after release, WAIT lasts cfg_rate+1 cycles, then READY.
REQ-034 CNTR_WIDTH=4, 20 accepts -> sts_count saturates at 15; the 16th and later accepts leave it at 15 while sts_data still updates.
REQ-035 areset asserted for one cycle in READY with tvalid high -> all status outputs = 0, tready = 0 next cycle, and the beat is not counted.
